// File: rtl/paddle_game_ctrl_if.sv
// rtl/paddle_game_ctrl_if.sv - button, ball and paddle signal bundle for the game sequencer
interface paddle_game_ctrl_if;
   logic       tick;
   logic       btn_start;
   logic       btn_pause;
   logic       btn_left;
   logic       btn_right;
   logic       ball_missed;
   logic [9:0] x_pos;
   logic [9:0] screen_width;
   logic [9:0] paddle_width;
   logic       move_left;
   logic       move_right;
   logic       paddle_reset;
   logic       paddle_pause;
   logic       ball_launch;
   logic [2:0] lives;
   logic [2:0] state;
   logic       game_over;

   modport master (
      output tick, btn_start, btn_pause, btn_left, btn_right, ball_missed,
             x_pos, screen_width, paddle_width,
      input  move_left, move_right, paddle_reset, paddle_pause, ball_launch,
             lives, state, game_over
   );

   modport slave (
      input  tick, btn_start, btn_pause, btn_left, btn_right, ball_missed,
             x_pos, screen_width, paddle_width,
      output move_left, move_right, paddle_reset, paddle_pause, ball_launch,
             lives, state, game_over
   );
endinterface

// File: rtl/paddle_game_ctrl.sv
// rtl/paddle_game_ctrl.sv - serve/play/pause/over sequencer with rate-limited, edge-clamped paddle moves
module paddle_game_ctrl #(
   parameter int LIVES       = 3,
   parameter int SERVE_TICKS = 60,
   parameter int MOVE_DIV    = 2,
   parameter int STEP        = 2
) (
   input logic               clk,
   input logic               reset,
   paddle_game_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SERVE  = 3'd1,
      PLAY   = 3'd2,
      PAUSED = 3'd3,
      OVER   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  lives_q, lives_d;
   logic [7:0]  serve_q, serve_d;
   logic [3:0]  div_q, div_d;
   logic        start_prev, pause_prev;
   logic        move_left_q, move_left_d, move_right_q, move_right_d;
   logic        launch_q, launch_d, preset_q, preset_d, ppause_q, ppause_d;
   logic        over_q, over_d;
   logic        start_edge, pause_edge, dir_l, dir_r, move_en, miss_reset;
   logic        left_ok, right_ok;
   logic [10:0] right_sum;

   assign start_edge = bus.btn_start & ~start_prev;
   assign pause_edge = bus.btn_pause & ~pause_prev;
   assign dir_l      = bus.btn_left & ~bus.btn_right;
   assign dir_r      = bus.btn_right & ~bus.btn_left;
   assign move_en    = (state_q == SERVE) || (state_q == PLAY);
   // 11-bit sum so a paddle near the right edge cannot wrap past the clamp
   assign right_sum  = {1'b0, bus.x_pos} + {1'b0, bus.paddle_width} + 11'(STEP);
   assign left_ok    = bus.x_pos >= 10'(STEP);
   assign right_ok   = right_sum <= {1'b0, bus.screen_width};

   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      serve_d      = serve_q;
      div_d        = div_q;
      move_left_d  = 1'b0;
      move_right_d = 1'b0;
      launch_d     = 1'b0;
      miss_reset   = 1'b0;

      if (move_en) begin
         if (!(dir_l || dir_r)) begin
            div_d = '0;
         end else if (bus.tick) begin
            if (div_q == '0) begin
               move_left_d  = dir_l & left_ok;
               move_right_d = dir_r & right_ok;
            end
            div_d = (div_q >= 4'(MOVE_DIV - 1)) ? '0 : div_q + 4'd1;
         end
      end

      case (state_q)
         IDLE: begin
            if (start_edge) begin
               state_d = SERVE;
               serve_d = '0;
            end
         end
         SERVE: begin
            if (bus.tick) begin
               serve_d = serve_q + 8'd1;
               if ({1'b0, serve_q} + 9'd1 == 9'(SERVE_TICKS)) begin
                  launch_d = 1'b1;
                  state_d  = PLAY;
               end
            end
         end
         PLAY: begin
            // a miss wins over a simultaneous pause edge, which is dropped
            if (bus.ball_missed) begin
               if (lives_q > 3'd1) begin
                  lives_d    = lives_q - 3'd1;
                  miss_reset = 1'b1;
                  serve_d    = '0;
                  state_d    = SERVE;
               end else begin
                  lives_d = '0;
                  state_d = OVER;
               end
            end else if (pause_edge) begin
               state_d = PAUSED;
            end
         end
         PAUSED: begin
            if (pause_edge) state_d = PLAY;
         end
         OVER: begin
            if (start_edge) begin
               state_d = IDLE;
               lives_d = 3'(LIVES);
            end
         end
         default: state_d = IDLE;
      endcase

      preset_d = (state_d == IDLE) || miss_reset;
      ppause_d = (state_d == IDLE) || (state_d == PAUSED) || (state_d == OVER);
      over_d   = (state_d == OVER);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         lives_q      <= 3'(LIVES);
         serve_q      <= '0;
         div_q        <= '0;
         start_prev   <= 1'b0;
         pause_prev   <= 1'b0;
         move_left_q  <= 1'b0;
         move_right_q <= 1'b0;
         launch_q     <= 1'b0;
         preset_q     <= 1'b1;
         ppause_q     <= 1'b1;
         over_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lives_q      <= lives_d;
         serve_q      <= serve_d;
         div_q        <= div_d;
         start_prev   <= bus.btn_start;
         pause_prev   <= bus.btn_pause;
         move_left_q  <= move_left_d;
         move_right_q <= move_right_d;
         launch_q     <= launch_d;
         preset_q     <= preset_d;
         ppause_q     <= ppause_d;
         over_q       <= over_d;
      end
   end

   assign bus.move_left    = move_left_q;
   assign bus.move_right   = move_right_q;
   assign bus.paddle_reset = preset_q;
   assign bus.paddle_pause = ppause_q;
   assign bus.ball_launch  = launch_q;
   assign bus.lives        = lives_q;
   assign bus.state        = state_q;
   assign bus.game_over    = over_q;

endmodule

// File: doc/paddle_game_ctrl.md
# paddle_game_ctrl

Game-sequencing controller for the breakout paddle datapath. It turns debounced player buttons into rate-limited, edge-clamped `move_left`/`move_right` pulses and drives the paddle's `reset`/`pause` inputs. It runs the serve/play/pause/game-over state machine and tracks remaining lives. It sits between the button debouncers and the paddle and ball blocks, all in the single `clk` domain.

## Interface
- `LIVES`, 3: lives loaded at reset and on restart; legal range 1..7.
- `SERVE_TICKS`, 60: `tick` count spent in SERVE before launch; legal range 1..255.
- `MOVE_DIV`, 2: ticks per move pulse while a direction button is held; legal range 1..15.
- `STEP`, 2: pixels the paddle moves per pulse; used only for edge clamping.

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `tick`  in  1  one-cycle frame strobe (one per video frame).
- `btn_start`  in  1  debounced level.
- `btn_pause`  in  1  debounced level.
- `btn_left`  in  1  debounced level.
- `btn_right`  in  1  debounced level.
- `ball_missed`  in  1  one-cycle pulse from the ball block.
- `x_pos`  in  10  current paddle X (left edge).
- `screen_width`  in  10  screen width in pixels.
- `paddle_width`  in  10  paddle width in pixels.
- `move_left`  out  1  one-cycle move pulse to the paddle.
- `move_right`  out  1  one-cycle move pulse to the paddle.
- `paddle_reset`  out  1  recentres the paddle.
- `paddle_pause`  out  1  freezes the paddle.
- `ball_launch`  out  1  one-cycle serve pulse to the ball block.
- `lives`  out  3  remaining lives.
- `state`  out  3  current state encoding.
- `game_over`  out  1  high in OVER.

## Operation
- Every output is a registered flop.
- Reset values:
  - state = IDLE
  - `lives` = LIVES
  - `paddle_reset` = 1, `paddle_pause` = 1
  - `move_left`, `move_right`, `ball_launch`, `game_over` = 0
  - all counters and edge-detect flops = 0
- Edge detect: `start_edge` = `btn_start` & ~previous sample; `pause_edge` is formed the same way. The previous-sample flops update every cycle, in every state.
- State encodings: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, OVER=4. Unused encodings go to IDLE on the next cycle.
- IDLE:
  - `paddle_reset`=1, `paddle_pause`=1.
  - `start_edge` → SERVE, and the serve counter is cleared.
- SERVE:
  - `paddle_reset`=0, `paddle_pause`=0; movement is enabled.
  - The serve counter increments on each `tick`.
  - On the tick that brings the count to SERVE_TICKS: `ball_launch`=1 for one cycle, and the state goes to PLAY.
- PLAY:
  - Movement is enabled.
  - `ball_missed` with `lives` > 1: decrement `lives`, pulse `paddle_reset` for one cycle, clear the serve counter, go to SERVE.
  - `ball_missed` with `lives` == 1: set `lives`=0 and go to OVER.
  - Otherwise, `pause_edge` → PAUSED.
- PAUSED:
  - `paddle_pause`=1; movement is suppressed; the move divider is frozen (it is not cleared).
  - `pause_edge` → PLAY.
- OVER:
  - `game_over`=1, `paddle_pause`=1.
  - `start_edge` → IDLE and reload `lives`=LIVES.
- Move generator (active only in SERVE and PLAY):
  - `dir_l` = `btn_left` & ~`btn_right`; `dir_r` is the mirror.
  - If neither or both buttons are held, the divider is cleared to 0.
  - On a `tick` with the divider at 0, a pulse is issued in the held direction. The divider then counts modulo MOVE_DIV. The first pulse therefore comes on the first tick after the press.
- Edge clamp:
  - Suppress the left pulse if `x_pos` < STEP.
  - Suppress the right pulse if `x_pos` + `paddle_width` + STEP > `screen_width`. This sum is computed 11 bits wide, so it cannot wrap.
  - A suppressed pulse still advances the divider.
- `move_left` and `move_right` are never high in the same cycle.

## Timing
- Control inputs sampled at edge N take effect in registered outputs at edge N+1.
- `move_*` pulses are one cycle wide and are asserted in the cycle after the qualifying `tick`.
- Launch timing: `ball_launch` asserts one cycle after the SERVE_TICKS-th tick counted in SERVE. `state` reads PLAY in that same cycle.
- Simultaneous events in PLAY:
  - `ball_missed` beats `pause_edge`. The pause edge is dropped.
  - A move pulse on the same tick as a miss is still issued.
- `ball_missed` outside PLAY is ignored.
- `start_edge` outside IDLE and OVER is ignored.
- `pause_edge` outside PLAY and PAUSED is ignored.
- A held `btn_start` does not retrigger; a new rising edge is required.
- Asynchronous `reset` mid-game forces the reset values immediately, with no `ball_launch` glitch. The first legal transition is IDLE→SERVE on the first `start_edge` after reset deasserts.

## Test plan
- Start sequence:
  - Stimulus: reset, then `btn_start` rising, then 60 ticks.
  - Required: `state` goes 0→1, then `ball_launch` pulses exactly once, 1 cycle after the 60th tick, and `state`=2.
- Move rate:
  - Stimulus: in PLAY, hold `btn_left` for 10 ticks with MOVE_DIV=2 and `x_pos`=300.
  - Required: exactly 5 `move_left` pulses, on ticks 1, 3, 5, 7, 9.
  - Stimulus: hold both buttons.
  - Required: zero pulses.
- Clamp:
  - Stimulus: `x_pos`=1, hold `btn_left`.
  - Required: no pulses.
  - Stimulus: `screen_width`=640, `paddle_width`=80, `x_pos`=559, hold `btn_right`.
  - Required: no pulses.
  - Stimulus: same, with `x_pos`=558.
  - Required: pulses.
- Lives:
  - Stimulus: LIVES=3, three `ball_missed` pulses in PLAY.
  - Required: after the first two misses, `lives` goes 2 then 1, with a 1-cycle `paddle_reset` pulse each time and a return to SERVE.
  - After the third miss: `lives`=0, `state`=4, `game_over`=1.
  - Stimulus: then `btn_start` rising.
  - Required: IDLE with `lives`=3.
- Pause:
  - Stimulus: `btn_pause` rising in PLAY while holding `btn_right`.
  - Required: `state`=3, `paddle_pause`=1, no pulses.
  - Stimulus: second `btn_pause` rising.
  - Required: PLAY, and pulses resume from the frozen divider phase.
- Collision and reset:
  - Stimulus: `ball_missed` and `pause_edge` in the same cycle.
  - Required: SERVE, not PAUSED.
  - Stimulus: `reset` asserted mid-SERVE.
  - Required: immediate IDLE, `lives`=3, no `ball_launch`.
